dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on posedge clk).
REQ-003 SHALL have ports a_req / b_req, input, 1 each, access request from requester A (CPU) / B (loader).
REQ-004 SHALL have ports a_we / b_we, input, 1 each, 1 = write, 0 = read.
REQ-005 SHALL have ports a_addr / b_addr, input, 32 each, byte address; word index = addr[11:2].
REQ-006 SHALL have ports a_wd / b_wd, input, 32 each, write data.
REQ-007 SHALL have ports a_gnt / b_gnt, output, 1 each, combinational grant; command accepted at the next posedge.
REQ-008 SHALL have ports a_rvalid / b_rvalid, output, 1 each, one-cycle pulse qualifying a_rd / b_rd.
REQ-009 SHALL have ports a_rd / b_rd, output, 32 each, registered read data.
REQ-010 SHALL have ports mem_we (1), mem_addr (32), mem_wd (32), outputs, command to the shared 1024x32 data memory (combinational read, posedge write).
REQ-011 SHALL have port mem_rd, input, 32, memory combinational read data.
REQ-012 SHALL have port busy, output, 1, high while stage S1 holds a valid command.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt of a port only when its req=1 and reset=1.
REQ-014 SHALL, on a posedge with x_gnt=1, latch {port, we, addr, wd} into stage S1 and set S1.valid=1; otherwise S1.valid=0 (one command per cycle, no bubbles).
REQ-015 SHALL drive mem_addr/mem_wd from S1 and mem_we = S1.valid & S1.we; mem_we=0, mem_addr=0, mem_wd=0 when S1.valid=0.
REQ-016 SHALL, at the posedge ending an S1 read, load mem_rd into the owning port's x_rd and pulse x_rvalid for exactly one cycle; non-owning port rd holds its value, rvalid=0.
REQ-017 SHALL give read latency: gnt in cycle k -> rvalid in cycle k+2; writes commit to memory at posedge ending cycle k+1 with no rvalid.
REQ-018 SHALL keep requester obligations: req/we/addr/wd stable until the cycle gnt=1; requester may re-request the following cycle (back-to-back accepted).
REQ-019 SHALL return, for a read granted the cycle after a write to the same word, the newly written data (write precedes read in memory).
REQ-020 SHALL use a last-served pointer updated only on a grant; with single requester that requester always wins.
REQ-021 SHALL not depend on a_addr/b_addr[1:0] or [31:12] for word selection; full 32-bit addr passed through to mem_addr.

Reset
REQ-022 SHALL, when reset=0 at posedge: S1.valid=0, a_rd=b_rd=0, a_rvalid=b_rvalid=0, pointer = "B last served"; busy, mem_we, mem_addr, mem_wd = 0 the following cycle.
REQ-023 SHALL, while reset=0, force a_gnt=b_gnt=0; in-flight S1 command at reset is discarded (no write, no rvalid).
REQ-024 SHALL accept requests the first cycle reset=1; A wins first tie.

Configuration
REQ-025 SHALL use macro DM_ARBITER_RR_EN: defined -> round-robin (on tie, port not last served wins); undefined -> fixed priority, A always wins ties, pointer logic absent.

Verification
REQ-026 SHALL cover: A writes addr 0x00000010 wd 0x12345678, then A reads 0x10 next cycle -> mem_we=1 once, a_rvalid two cycles after read gnt with a_rd=0x12345678.
REQ-027 SHALL cover: a_req and b_req both held high 4 cycles, reads of 0x0 / 0x4 (RR_EN defined) -> gnt order A,B,A,B; (undefined) -> A,A,A,A, b_gnt=0.
REQ-028 SHALL cover: B writes 0x000007FC wd 0xDEADBEEF, A reads 0x000017FC -> a_rd=0xDEADBEEF (addr[11:2] aliasing).
REQ-029 SHALL cover: reset=0 asserted the cycle after a write gnt -> mem_we stays 0, memory word unchanged, no rvalid, busy=0.
REQ-030 SHALL cover: continuous A reads of 0x0,0x4,0x8 on consecutive cycles -> a_gnt=1 each cycle, a_rvalid=1 three consecutive cycles with matching data.
REQ-031 SHALL cover: reset released with a_req=b_req=1 -> a_gnt=1 in first cycle.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port (A=CPU, B=loader) arbiter onto a single 1024x32 data memory; DM_ARBITER_RR_EN selects round-robin, else A has fixed priority.
// Grant is combinational, one command/cycle through stage S1; reads return 2 cycles after grant, requesters wait on gnt.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        b_req,
  input  logic        a_we,
  input  logic        b_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] b_addr,
  input  logic [31:0] a_wd,
  input  logic [31:0] b_wd,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [31:0] a_rd,
  output logic [31:0] b_rd,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  logic        s1_valid;
  logic        s1_port;   // 1 = command belongs to B
  logic        s1_we;
  logic [31:0] s1_addr;
  logic [31:0] s1_wd;

`ifdef DM_ARBITER_RR_EN
  logic last_b;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset) begin
      if (a_req && b_req) begin
        a_gnt = last_b;
        b_gnt = !last_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Pointer starts as "B last served" so A wins the first tie out of reset.
  always_ff @(posedge clk) begin
    if (!reset)
      last_b <= 1'b1;
    else if (a_gnt || b_gnt)
      last_b <= b_gnt;
  end
`else
  assign a_gnt = reset & a_req;
  assign b_gnt = reset & b_req & ~a_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
      s1_we    <= 1'b0;
      s1_addr  <= 32'd0;
      s1_wd    <= 32'd0;
    end else begin
      s1_valid <= a_gnt | b_gnt;
      if (a_gnt) begin
        s1_port <= 1'b0;
        s1_we   <= a_we;
        s1_addr <= a_addr;
        s1_wd   <= a_wd;
      end else if (b_gnt) begin
        s1_port <= 1'b1;
        s1_we   <= b_we;
        s1_addr <= b_addr;
        s1_wd   <= b_wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rd     <= 32'd0;
      b_rd     <= 32'd0;
    end else begin
      a_rvalid <= s1_valid & ~s1_we & ~s1_port;
      b_rvalid <= s1_valid & ~s1_we & s1_port;
      if (s1_valid && !s1_we && !s1_port)
        a_rd <= mem_rd;
      if (s1_valid && !s1_we && s1_port)
        b_rd <= mem_rd;
    end
  end

  // Gating with reset drops a write still sitting in S1 when reset lands.
  assign mem_we   = s1_valid & s1_we & reset;
  assign mem_addr = s1_valid ? s1_addr : 32'd0;
  assign mem_wd   = s1_valid ? s1_wd : 32'd0;
  assign busy     = s1_valid;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1024x32 memory (combinational read, posedge write).
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req, a_we, b_we;
  logic [31:0] a_addr, b_addr, a_wd, b_wd;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rd, b_rd;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        busy;

  logic [31:0] tmem [0:1023];
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_dat;

  int checks = 0;
  int errors = 0;

  logic [7:0] ga, gb;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_wd(a_wd), .b_wd(b_wd),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rd(a_rd), .b_rd(b_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  assign mem_rd = tmem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (load_en)
      tmem[load_idx] <= load_dat;
    else if (mem_we)
      tmem[mem_addr[11:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef DM_ARBITER_RR_EN
    ga = 8'b0000_0101;
    gb = 8'b0000_1010;
`else
    ga = 8'b0000_1111;
    gb = 8'b0000_0000;
`endif
    reset = 1'b0;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wd = 0; b_wd = 0;
    load_en = 0; load_idx = 0; load_dat = 0;
    #1;

    // Preload words 0,1,2,8 while in reset
    for (int i = 0; i < 4; i++) begin
      load_en  = 1'b1;
      load_idx = (i == 3) ? 10'd8 : 10'(i);
      load_dat = (i == 3) ? 32'h0BADC0DE : 32'h11111111 * (i + 1);
      next_cycle();
    end
    load_en = 1'b0;

    // Requests held during reset must not be granted
    a_req = 1; b_req = 1; a_addr = 32'h0; b_addr = 32'h4;
    @(negedge clk);
    check("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    check("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    check("rst_a_rd", a_rd, 32'd0);
    check("rst_b_rd", b_rd, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Tie burst straight out of reset: A first, then policy-dependent order
    for (int i = 0; i < 6; i++) begin
      a_req = (i < 4);
      b_req = (i < 4);
      @(negedge clk);
      check($sformatf("burst_a_gnt%0d", i), {31'd0, a_gnt}, {31'd0, ga[i]});
      check($sformatf("burst_b_gnt%0d", i), {31'd0, b_gnt}, {31'd0, gb[i]});
      if (i >= 2) begin
        check($sformatf("burst_a_rvalid%0d", i), {31'd0, a_rvalid}, {31'd0, ga[i-2]});
        check($sformatf("burst_b_rvalid%0d", i), {31'd0, b_rvalid}, {31'd0, gb[i-2]});
        if (ga[i-2]) check($sformatf("burst_a_rd%0d", i), a_rd, 32'h11111111);
        if (gb[i-2]) check($sformatf("burst_b_rd%0d", i), b_rd, 32'h22222222);
      end
      next_cycle();
    end

    // A writes 0x10 then reads it back the next cycle
    a_req = 1; a_we = 1; a_addr = 32'h10; a_wd = 32'h12345678;
    @(negedge clk);
    check("wr_a_gnt", {31'd0, a_gnt}, 32'd1);
    check("wr_mem_we_idle", {31'd0, mem_we}, 32'd0);
    next_cycle();
    a_we = 0; a_wd = 0;
    @(negedge clk);
    check("rd_a_gnt", {31'd0, a_gnt}, 32'd1);
    check("wr_mem_we", {31'd0, mem_we}, 32'd1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wd", mem_wd, 32'h12345678);
    check("wr_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    a_req = 0;
    @(negedge clk);
    check("rd_mem_we", {31'd0, mem_we}, 32'd0);
    check("rd_mem_addr", mem_addr, 32'h10);
    check("rd_rvalid_early", {31'd0, a_rvalid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("rd_a_rd", a_rd, 32'h12345678);
    check("rd_idle_busy", {31'd0, busy}, 32'd0);
    check("rd_idle_mem_we", {31'd0, mem_we}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("rd_a_rvalid_pulse", {31'd0, a_rvalid}, 32'd0);
    check("rd_a_rd_hold", a_rd, 32'h12345678);

    // B writes 0x7FC, A reads the aliased 0x17FC
    next_cycle();
    b_req = 1; b_we = 1; b_addr = 32'h7FC; b_wd = 32'hDEADBEEF;
    @(negedge clk);
    check("al_b_gnt", {31'd0, b_gnt}, 32'd1);
    check("al_a_gnt0", {31'd0, a_gnt}, 32'd0);
    next_cycle();
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 32'h17FC;
    @(negedge clk);
    check("al_a_gnt", {31'd0, a_gnt}, 32'd1);
    check("al_mem_we", {31'd0, mem_we}, 32'd1);
    check("al_mem_addr_w", mem_addr, 32'h7FC);
    next_cycle();
    a_req = 0;
    @(negedge clk);
    check("al_mem_addr_r", mem_addr, 32'h17FC);
    next_cycle();
    @(negedge clk);
    check("al_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    check("al_a_rd", a_rd, 32'hDEADBEEF);
    check("al_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    next_cycle();

    // Back-to-back A reads of 0x0, 0x4, 0x8
    for (int i = 0; i < 6; i++) begin
      a_req  = (i < 3);
      a_addr = 32'(i * 4);
      @(negedge clk);
      check($sformatf("b2b_a_gnt%0d", i), {31'd0, a_gnt}, {31'd0, (i < 3)});
      if (i >= 2) begin
        check($sformatf("b2b_a_rvalid%0d", i), {31'd0, a_rvalid}, {31'd0, (i < 5)});
        if (i < 5) check($sformatf("b2b_a_rd%0d", i), a_rd, 32'h11111111 * (i - 1));
      end
      next_cycle();
    end

    // Reset lands while a granted write sits in S1
    a_req = 1; a_we = 1; a_addr = 32'h20; a_wd = 32'hCAFEF00D;
    @(negedge clk);
    check("rw_a_gnt", {31'd0, a_gnt}, 32'd1);
    next_cycle();
    a_req = 0; a_we = 0; a_wd = 0; a_addr = 0;
    reset = 1'b0;
    @(negedge clk);
    check("rw_mem_we_in_reset", {31'd0, mem_we}, 32'd0);
    next_cycle();
    reset = 1'b1;
    a_req = 1; b_req = 1; b_addr = 32'h4;
    @(negedge clk);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_mem_we", {31'd0, mem_we}, 32'd0);
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("rw_a_rd", a_rd, 32'd0);
    check("rw_word", tmem[8], 32'h0BADC0DE);
    check("rw_tie_a_gnt", {31'd0, a_gnt}, 32'd1);
    check("rw_tie_b_gnt", {31'd0, b_gnt}, 32'd0);
    next_cycle();
    a_req = 0; b_req = 0;
    @(negedge clk);
    check("rw_no_rvalid", {31'd0, a_rvalid}, 32'd0);
    check("rw_word_after", tmem[8], 32'h0BADC0DE);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
